// File: rtl/aes_pkg.sv
// Shared types and sizing for the AES-256 host word loader.
// Holds the loader state encoding and the ciphertext word-select helper.
package aes_pkg;

    localparam int AES_KEY_WORDS = 8;
    localparam int AES_BLK_WORDS = 4;
    localparam int AES_WORD_W    = 32;

    typedef enum logic [1:0] {
        LOAD,
        START,
        BUSY,
        DRAIN
    } state_e;

    // Big-endian word select: idx 0 is the most significant word of the block.
    function automatic logic [AES_WORD_W-1:0] blk_word(input logic [127:0] blk,
                                                       input logic [1:0]   idx);
        return blk[(AES_BLK_WORDS - 1 - int'(idx)) * AES_WORD_W +: AES_WORD_W];
    endfunction

endpackage

// File: rtl/aes_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT; TIMEOUT = 0 disables it.
module aes_watchdog #(
    parameter int unsigned TIMEOUT = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr, en};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT + 1);
            logic [W-1:0] cnt_q;

            // Expiry is flagged one count early so the abort lands on the edge
            // where the count would reach TIMEOUT.
            assign expired = en && (cnt_q == W'(TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_q <= '0;
                end else if (en && !expired) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/aes_word_loader.sv
// Host-side word loader for the AES-256 encrypt core: packs key/plaintext
// words, starts the core, and streams the ciphertext back. Macro AES_KEY_REUSE_EN.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AES_WORD_W-1:0] in_data,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [255:0]          core_key,
    output logic [127:0]          core_data,
    output logic                  core_start,
    input  logic [127:0]          core_result,
    input  logic                  core_valid,
    output logic [AES_WORD_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err
);

    state_e                  state_q;
    logic [255:0]            key_q;
    logic [127:0]            data_q;
    logic [127:0]            result_q;
    logic [3:0]              key_cnt_q;
    logic [2:0]              data_cnt_q;
    logic                    key_loaded_q;
    logic [1:0]              idx_q;
    logic                    start_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [AES_WORD_W-1:0]   out_data_q;
    logic                    err_q;
    logic                    accept;
    logic                    wd_expired;

    assign in_ready = (state_q == LOAD) &&
                      !(!in_is_key && (data_cnt_q == 3'(AES_BLK_WORDS)));
    assign accept   = in_valid && in_ready;

    aes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == START),
        .en      (state_q == BUSY),
        .expired (wd_expired)
    );

    // NOTE: the key/data registers are reset too, because core_key and
    // core_data must read zero after reset rather than stale host words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            key_q        <= '0;
            data_q       <= '0;
            result_q     <= '0;
            key_cnt_q    <= '0;
            data_cnt_q   <= '0;
            key_loaded_q <= 1'b0;
            idx_q        <= '0;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (accept && in_is_key) begin
                        if (key_cnt_q == 4'(AES_KEY_WORDS)) begin
                            // A ninth key word begins a fresh key at word 0.
                            key_q[255 -: AES_WORD_W] <= in_data;
                            key_cnt_q                <= 4'd1;
                            key_loaded_q             <= 1'b0;
                        end else begin
                            key_q[(AES_KEY_WORDS - 1 - int'(key_cnt_q)) * AES_WORD_W +: AES_WORD_W] <= in_data;
                            key_cnt_q <= key_cnt_q + 4'd1;
                            if (key_cnt_q == 4'(AES_KEY_WORDS - 1)) key_loaded_q <= 1'b1;
                        end
                    end
                    if (accept && !in_is_key) begin
                        data_q[(AES_BLK_WORDS - 1 - int'(data_cnt_q)) * AES_WORD_W +: AES_WORD_W] <= in_data;
                        data_cnt_q <= data_cnt_q + 3'd1;
                    end
                    if (data_cnt_q == 3'(AES_BLK_WORDS) && key_loaded_q) begin
                        state_q <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    state_q <= BUSY;
`ifdef AES_KEY_REUSE_EN
                    key_loaded_q <= key_loaded_q;
`else
                    key_loaded_q <= 1'b0;
                    key_cnt_q    <= '0;
`endif
                end
                BUSY: begin
                    if (core_valid) begin
                        result_q    <= core_result;
                        out_data_q  <= blk_word(core_result, 2'd0);
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        idx_q       <= 2'd0;
                        state_q     <= DRAIN;
                    end else if (wd_expired) begin
                        err_q      <= 1'b1;
                        data_cnt_q <= '0;
                        state_q    <= LOAD;
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (idx_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            idx_q       <= 2'd0;
                            data_cnt_q  <= '0;
                            state_q     <= LOAD;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            out_data_q <= blk_word(result_q, idx_q + 2'd1);
                            out_last_q <= (idx_q == 2'd2);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign core_key   = key_q;
    assign core_data  = data_q;
    assign core_start = start_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign err        = err_q;

endmodule
